// File: rtl/loop_countdown_if.sv
// Beat channel of the down-counting loop index generator.
// master drives out_valid/inner_count/outer_count/last; slave drives out_ready.
interface loop_countdown_if #(
  parameter int DATA_WIDTH = 4
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] inner_count;
  logic [DATA_WIDTH-1:0] outer_count;
  logic                  last;

  modport master (
    output out_valid,
    output inner_count,
    output outer_count,
    output last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  inner_count,
    input  outer_count,
    input  last,
    output out_ready
  );
endinterface

// File: rtl/loop_countdown.sv
// Two-level nested loop index generator counting down by a stride to zero.
// Ports: clk, reset_n (async low), start, inner/outer max and stride,
// beat (loop_countdown_if.master: out_valid/out_ready/counts/last),
// busy, done. Optional abort input when LOOP_COUNTDOWN_ABORT_EN is defined.
module loop_countdown #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] inner_max,
  input  logic [DATA_WIDTH-1:0] inner_stride,
  input  logic [DATA_WIDTH-1:0] outer_max,
  input  logic [DATA_WIDTH-1:0] outer_stride,
`ifdef LOOP_COUNTDOWN_ABORT_EN
  input  logic                  abort,
`endif
  loop_countdown_if.master      beat,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] inner_q, inner_d;
  logic [DATA_WIDTH-1:0] outer_q, outer_d;
  logic [DATA_WIDTH-1:0] imax_q, imax_d;
  logic [DATA_WIDTH-1:0] istr_q, istr_d;
  logic [DATA_WIDTH-1:0] omax_q, omax_d;
  logic [DATA_WIDTH-1:0] ostr_q, ostr_d;

  logic inner_wrap;
  logic outer_wrap;
  logic accept;
  logic kill;

  // Wrap is tested before subtracting so counts never underflow.
  assign inner_wrap = (inner_q < istr_q);
  assign outer_wrap = (outer_q < ostr_q);
  assign accept     = (state == RUN) && beat.out_ready;

`ifdef LOOP_COUNTDOWN_ABORT_EN
  assign kill = (state == RUN) && abort;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      inner_q <= '0;
      outer_q <= '0;
      imax_q  <= '0;
      istr_q  <= '0;
      omax_q  <= '0;
      ostr_q  <= '0;
    end else begin
      state   <= state_n;
      inner_q <= inner_d;
      outer_q <= outer_d;
      imax_q  <= imax_d;
      istr_q  <= istr_d;
      omax_q  <= omax_d;
      ostr_q  <= ostr_d;
    end
  end

  always_comb begin
    state_n = state;
    inner_d = inner_q;
    outer_d = outer_q;
    imax_d  = imax_q;
    istr_d  = istr_q;
    omax_d  = omax_q;
    ostr_d  = ostr_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          imax_d  = inner_max;
          omax_d  = outer_max;
          istr_d  = (inner_stride == '0) ? ONE : inner_stride;
          ostr_d  = (outer_stride == '0) ? ONE : outer_stride;
          inner_d = inner_max;
          outer_d = outer_max;
          state_n = RUN;
        end
      end
      RUN: begin
        // Abort wins over a beat accepted in the same cycle.
        if (kill) begin
          state_n = DONE;
        end else if (accept) begin
          unique case (1'b1)
            !inner_wrap: begin
              inner_d = inner_q - istr_q;
            end
            inner_wrap && !outer_wrap: begin
              inner_d = imax_q;
              outer_d = outer_q - ostr_q;
            end
            default: begin
              state_n = DONE;
            end
          endcase
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign beat.out_valid   = (state == RUN);
  assign beat.inner_count = inner_q;
  assign beat.outer_count = outer_q;
  assign beat.last        = (state == RUN) && inner_wrap && outer_wrap;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

endmodule
